// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - run-mode FSM, execute latency counter and pipeline register update codes
module pipe_ctrl #(
  parameter int NSTAGE = 4,
  parameter int EX_IDX = 2,
  parameter int LAT_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    boot_req,
  input  logic                    load_done,
  input  logic                    boot_ack,
  input  logic [LAT_W-1:0]        ex_wait,
  input  logic                    ex_busy,
  input  logic                    ex_valid,
  input  logic                    hazard,
  input  logic                    redirect,
  input  logic                    halt_req,
  input  logic                    resume,
  output logic [2*(NSTAGE-1)-1:0] upd,
  output logic [1:0]              mode,
  output logic                    ex_done,
  output logic                    ex_start,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        retire_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, HALT = 2'd3} mode_t;

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] ADV   = 2'b01;
  localparam logic [1:0] FLUSH = 2'b10;

  mode_t            mode_q;
  logic [LAT_W-1:0] lat;

  assign mode    = mode_q;
  // >= rather than == so a shrinking ex_wait mid-instruction still completes
  assign ex_done = (mode_q == EXEC) && (lat >= ex_wait) && !ex_busy;

  always_comb begin
    upd = '0;
    for (int k = 0; k < NSTAGE-1; k++) begin
      if (mode_q == IDLE || mode_q == LOAD) begin
        upd[2*k +: 2] = FLUSH;
      end else if (ex_done) begin
        if (k >= EX_IDX)
          upd[2*k +: 2] = ADV;
        else if (redirect)
          upd[2*k +: 2] = (k == 0) ? ADV : FLUSH;
        else if (hazard)
          upd[2*k +: 2] = (k == EX_IDX-1) ? FLUSH : HOLD;
        else
          upd[2*k +: 2] = ADV;
      end else begin
        upd[2*k +: 2] = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q     <= IDLE;
      lat        <= '0;
      ex_start   <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      ex_start <= ex_done;

      case (mode_q)
        IDLE:    if (boot_req) mode_q <= LOAD;
        LOAD:    if (load_done && boot_ack) mode_q <= EXEC;
        EXEC:    if (halt_req && ex_done) mode_q <= HALT;
        HALT: begin
          if (boot_req)    mode_q <= LOAD;
          else if (resume) mode_q <= EXEC;
        end
        default: mode_q <= IDLE;
      endcase

      if (mode_q != EXEC || ex_done)
        lat <= '0;
      else if (lat < ex_wait)
        lat <= lat + LAT_W'(1);

      // counters restart on every entry into LOAD and only advance in EXEC
      if (boot_req && (mode_q == IDLE || mode_q == HALT)) begin
        cycle_cnt  <= '0;
        retire_cnt <= '0;
      end else if (mode_q == EXEC) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (ex_done && ex_valid)
          retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule
